idex_stage: RTL and testbench
=============================

IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports IFID_RegisterRs and IFID_RegisterRt, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have port IFID_valid, input, 1, meaning ID holds a real instruction.
REQ-005 SHALL have ports ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc and ID_RegDst, input, 1 each, decoded controls.
REQ-006 SHALL have port ID_ALUOp, input, 2, ALU operation class.
REQ-007 SHALL have ports ID_ReadData1, ID_ReadData2 and ID_SignImm, input, 32 each, operands and immediate.
REQ-008 SHALL have port ID_RegisterRd, input, 5, rd field.
REQ-009 SHALL have port flush, input, 1, squash of the ID instruction (taken branch/jump).
REQ-010 SHALL have outputs IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_RegDst (1 each), IDEX_ALUOp (2), IDEX_ReadData1, IDEX_ReadData2, IDEX_SignImm (32 each), IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd (5 each) and IDEX_valid (1); all registered copies.
REQ-011 SHALL have outputs PCWrite and IFIDWrite, 1 each, combinational; 0 holds PC and IF/ID.
REQ-012 SHALL have output hazard_stall, 1, combinational load-use indication.

Function
REQ-013 SHALL compute hazard_stall = IDEX_valid & IDEX_MemRead & IFID_valid & (IDEX_RegisterRt != 0) & (IDEX_RegisterRt == IFID_RegisterRs | IDEX_RegisterRt == IFID_RegisterRt).
REQ-014 SHALL drive PCWrite = IFIDWrite = ~(hazard_stall & ~flush).
REQ-015 SHALL, on each edge with no flush and no hazard_stall, load every IDEX_* output from its ID_*/IFID_* source; IDEX_valid <= IFID_valid; latency 1 cycle.
REQ-016 SHALL, on an edge with hazard_stall=1 or flush=1, insert a bubble: IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_valid and IDEX_RegisterRs/Rt/Rd <= 0; other fields <= 0.
REQ-017 SHALL give flush priority over hazard_stall when both are asserted: bubble inserted, PCWrite=IFIDWrite=1.
REQ-018 SHALL limit a load-use stall to exactly one cycle: the bubble clears IDEX_MemRead, so hazard_stall deasserts on the next cycle for the held instruction.
REQ-019 SHALL never assert hazard_stall for a load whose destination is register 0, or when IFID_valid=0.
REQ-020 SHALL keep the bubble invisible downstream: bubble has RegWrite=0 and Rd=0, so no forwarding match occurs on it.

Reset
REQ-021 SHALL, while rst=1, force all IDEX_* outputs to 0 immediately without waiting for clk.
REQ-022 SHALL, while rst=1, hold hazard_stall=0 and PCWrite=IFIDWrite=1, because IDEX_valid=0.
REQ-023 SHALL, on rst asserted mid-stall, discard the pending stall; the first edge after release loads ID normally.

Configuration
REQ-024 SHALL support macro IDEX_STALL_CNT_EN: when defined, add output stall_count, 16, which increments on each edge where hazard_stall=1 and flush=0, saturates at 16'hFFFF and resets to 0.
REQ-025 SHALL, without IDEX_STALL_CNT_EN, omit the stall_count port and its counter entirely; all other behaviour is identical.

Verification
REQ-026 SHALL cover: lw $t0 in EX (IDEX_MemRead=1, IDEX_RegisterRt=8), ID has Rs=8 -> hazard_stall=1, PCWrite=0; next edge gives IDEX_valid=0, IDEX_RegWrite=0; the following edge loads the held instruction.
REQ-027 SHALL cover: load to Rt=0 with ID Rs=0 -> hazard_stall=0; the pipeline advances every cycle.
REQ-028 SHALL cover: hazard condition plus flush=1 -> PCWrite=1, bubble inserted, and stall_count unchanged (macro on).
REQ-029 SHALL cover: rst pulsed asynchronously between edges while IDEX_ReadData1=32'hDEADBEEF -> all outputs 0 before the next clk edge.
REQ-030 SHALL cover: 70000 consecutive forced hazard cycles with the macro on -> stall_count=16'hFFFF and holds; with the macro off -> the port is absent and the build is clean.

Source files
------------

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional stall counter output enabled by defining IDEX_STALL_CNT_EN.
module idex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFID_RegisterRs,
    input  logic [4:0]  IFID_RegisterRt,
    input  logic        IFID_valid,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic        ID_MemtoReg,
    input  logic        ID_ALUSrc,
    input  logic        ID_RegDst,
    input  logic [1:0]  ID_ALUOp,
    input  logic [31:0] ID_ReadData1,
    input  logic [31:0] ID_ReadData2,
    input  logic [31:0] ID_SignImm,
    input  logic [4:0]  ID_RegisterRd,
    input  logic        flush,
    output logic        IDEX_RegWrite,
    output logic        IDEX_MemRead,
    output logic        IDEX_MemWrite,
    output logic        IDEX_MemtoReg,
    output logic        IDEX_ALUSrc,
    output logic        IDEX_RegDst,
    output logic [1:0]  IDEX_ALUOp,
    output logic [31:0] IDEX_ReadData1,
    output logic [31:0] IDEX_ReadData2,
    output logic [31:0] IDEX_SignImm,
    output logic [4:0]  IDEX_RegisterRs,
    output logic [4:0]  IDEX_RegisterRt,
    output logic [4:0]  IDEX_RegisterRd,
    output logic        IDEX_valid,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        hazard_stall
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] sign_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
    } idex_t;

    idex_t id_pkt;
    idex_t idex_d;
    idex_t idex_q;
    logic  load_use;
    logic  bubble;

    always_comb begin
        id_pkt            = '0;
        id_pkt.reg_write  = ID_RegWrite;
        id_pkt.mem_read   = ID_MemRead;
        id_pkt.mem_write  = ID_MemWrite;
        id_pkt.mem_to_reg = ID_MemtoReg;
        id_pkt.alu_src    = ID_ALUSrc;
        id_pkt.reg_dst    = ID_RegDst;
        id_pkt.alu_op     = ID_ALUOp;
        id_pkt.read_data1 = ID_ReadData1;
        id_pkt.read_data2 = ID_ReadData2;
        id_pkt.sign_imm   = ID_SignImm;
        id_pkt.rs         = IFID_RegisterRs;
        id_pkt.rt         = IFID_RegisterRt;
        id_pkt.rd         = ID_RegisterRd;
        id_pkt.valid      = IFID_valid;
    end

    // A load writing $zero never creates a real dependency.
    assign load_use = idex_q.valid & idex_q.mem_read & IFID_valid &
                      (idex_q.rt != 5'd0) &
                      ((idex_q.rt == IFID_RegisterRs) | (idex_q.rt == IFID_RegisterRt));

    assign hazard_stall = load_use;
    assign PCWrite      = ~(hazard_stall & ~flush);
    assign IFIDWrite    = ~(hazard_stall & ~flush);
    assign bubble       = hazard_stall | flush;

    // The all-zero bubble clears MemRead, so a load-use stall lasts one cycle.
    always_comb begin
        idex_d = id_pkt;
        if (bubble) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign IDEX_RegWrite   = idex_q.reg_write;
    assign IDEX_MemRead    = idex_q.mem_read;
    assign IDEX_MemWrite   = idex_q.mem_write;
    assign IDEX_MemtoReg   = idex_q.mem_to_reg;
    assign IDEX_ALUSrc     = idex_q.alu_src;
    assign IDEX_RegDst     = idex_q.reg_dst;
    assign IDEX_ALUOp      = idex_q.alu_op;
    assign IDEX_ReadData1  = idex_q.read_data1;
    assign IDEX_ReadData2  = idex_q.read_data2;
    assign IDEX_SignImm    = idex_q.sign_imm;
    assign IDEX_RegisterRs = idex_q.rs;
    assign IDEX_RegisterRt = idex_q.rt;
    assign IDEX_RegisterRd = idex_q.rd;
    assign IDEX_valid      = idex_q.valid;

`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt_d;
    logic [15:0] stall_cnt_q;

    // Only stalls that actually hold the front end are counted; flushed ones are not.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: expected ID/EX contents are queued at drive
// time and compared after the clock edge; hazard outputs are checked combinationally.
module tb_idex_stage;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] sign_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IFID_RegisterRs, IFID_RegisterRt, ID_RegisterRd;
    logic        IFID_valid, flush;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
    logic [1:0]  ID_ALUOp;
    logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignImm;
    logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_RegDst;
    logic [1:0]  IDEX_ALUOp;
    logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_SignImm;
    logic [4:0]  IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd;
    logic        IDEX_valid, PCWrite, IFIDWrite, hazard_stall;
`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    idex_stage dut (
        .clk(clk), .rst(rst),
        .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
        .IFID_valid(IFID_valid),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_ALUOp(ID_ALUOp),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignImm(ID_SignImm),
        .ID_RegisterRd(ID_RegisterRd), .flush(flush),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
        .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_RegDst(IDEX_RegDst),
        .IDEX_ALUOp(IDEX_ALUOp),
        .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .IDEX_SignImm(IDEX_SignImm),
        .IDEX_RegisterRs(IDEX_RegisterRs), .IDEX_RegisterRt(IDEX_RegisterRt),
        .IDEX_RegisterRd(IDEX_RegisterRd), .IDEX_valid(IDEX_valid),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .hazard_stall(hazard_stall)
`ifdef IDEX_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    pkt_t        sb[$];
    pkt_t        ex_m;
    pkt_t        pending_m;
    logic        exp_haz;
    logic        exp_pcw;
    int unsigned cnt_m;

    function automatic pkt_t observed();
        pkt_t o;
        o = {IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_RegDst,
             IDEX_ALUOp, IDEX_ReadData1, IDEX_ReadData2, IDEX_SignImm,
             IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd, IDEX_valid};
        return o;
    endfunction

    function automatic pkt_t rand_pkt(input logic ld, input logic [4:0] rs, input logic [4:0] rt);
        pkt_t p;
        p.reg_write  = ld ? 1'b1 : 1'($urandom_range(0, 1));
        p.mem_read   = ld;
        p.mem_write  = ld ? 1'b0 : 1'($urandom_range(0, 1));
        p.mem_to_reg = ld;
        p.alu_src    = 1'($urandom_range(0, 1));
        p.reg_dst    = 1'($urandom_range(0, 1));
        p.alu_op     = 2'($urandom_range(0, 3));
        p.read_data1 = $urandom;
        p.read_data2 = $urandom;
        p.sign_imm   = $urandom;
        p.rs         = rs;
        p.rt         = rt;
        p.rd         = 5'($urandom_range(1, 31));
        p.valid      = 1'b1;
        return p;
    endfunction

    // Drive one ID instruction and queue the ID/EX contents the next edge must produce.
    task automatic drive(input pkt_t p, input logic f);
        @(negedge clk);
        IFID_RegisterRs = p.rs;         IFID_RegisterRt = p.rt;
        IFID_valid      = p.valid;      ID_RegisterRd   = p.rd;
        ID_RegWrite     = p.reg_write;  ID_MemRead      = p.mem_read;
        ID_MemWrite     = p.mem_write;  ID_MemtoReg     = p.mem_to_reg;
        ID_ALUSrc       = p.alu_src;    ID_RegDst       = p.reg_dst;
        ID_ALUOp        = p.alu_op;     ID_ReadData1    = p.read_data1;
        ID_ReadData2    = p.read_data2; ID_SignImm      = p.sign_imm;
        flush           = f;
        exp_haz = ex_m.valid && ex_m.mem_read && p.valid && (ex_m.rt != 5'd0) &&
                  ((ex_m.rt == p.rs) || (ex_m.rt == p.rt));
        exp_pcw = !(exp_haz && !f);
        pending_m = (exp_haz || f) ? pkt_t'('0) : p;
        sb.push_back(pending_m);
        if (exp_haz && !f && cnt_m != 32'hFFFF) cnt_m++;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        ex_m = pending_m;
        #1;
    endtask

    task automatic test_reset();
        pkt_t o;
        #2;
        o = observed();
        n_checks++;
        if (o !== pkt_t'('0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", o);
        end
        n_checks++;
        if ({hazard_stall, PCWrite, IFIDWrite} !== 3'b011) begin
            n_fail++;
            $display("FAIL reset_hazard: got %b, want 011", {hazard_stall, PCWrite, IFIDWrite});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pass();
        pkt_t p, e, o;
        for (int i = 0; i < 8; i++) begin
            p = rand_pkt(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            drive(p, 1'b0);
            n_checks++;
            if ({hazard_stall, PCWrite, IFIDWrite} !== 3'b011) begin
                n_fail++;
                $display("FAIL pass_hazard: got %b, want 011", {hazard_stall, PCWrite, IFIDWrite});
            end
            tick();
            e = sb.pop_front();
            o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pass_load: got %h, want %h", o, e);
            end
            $display("pass txn %0d: rs=%0d rt=%0d rd=%0d valid=%0b", i, o.rs, o.rt, o.rd, o.valid);
        end
    endtask

    task automatic test_load_use();
        pkt_t lw, add, e, o;
        lw  = rand_pkt(1'b1, 5'd2, 5'd8);
        add = rand_pkt(1'b0, 5'd8, 5'd3);
        drive(lw, 1'b0);
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL lu_load: got %h, want %h", o, e);
        end
        drive(add, 1'b0);
        n_checks++;
        if ({hazard_stall, PCWrite, IFIDWrite} !== {exp_haz, exp_pcw, exp_pcw} || exp_haz !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b, want 100", {hazard_stall, PCWrite, IFIDWrite});
        end
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e || IDEX_valid !== 1'b0 || IDEX_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble: got %h, want %h", o, e);
        end
        $display("load-use bubble: valid=%0b regwrite=%0b", IDEX_valid, IDEX_RegWrite);
        drive(add, 1'b0);
        n_checks++;
        if ({hazard_stall, PCWrite} !== 2'b01) begin
            n_fail++;
            $display("FAIL lu_release: got %b, want 01", {hazard_stall, PCWrite});
        end
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL lu_held: got %h, want %h", o, e);
        end
        $display("load-use held instr: rs=%0d rd=%0d", o.rs, o.rd);
`ifdef IDEX_STALL_CNT_EN
        n_checks++;
        if (stall_count !== 16'(cnt_m)) begin
            n_fail++;
            $display("FAIL lu_count: got %0d, want %0d", stall_count, cnt_m);
        end
`endif
    endtask

    task automatic test_no_hazard_cases();
        pkt_t p, e, o;
        // Load to $zero, consumer reads $zero; then load to $5 with invalid consumer.
        for (int k = 0; k < 2; k++) begin
            p = rand_pkt(1'b1, 5'd1, (k == 0) ? 5'd0 : 5'd5);
            drive(p, 1'b0);
            tick();
            e = sb.pop_front(); o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL nh_load%0d: got %h, want %h", k, o, e);
            end
            p = rand_pkt(1'b0, (k == 0) ? 5'd0 : 5'd5, (k == 0) ? 5'd0 : 5'd5);
            p.valid = (k == 0);
            drive(p, 1'b0);
            n_checks++;
            if ({hazard_stall, PCWrite, IFIDWrite} !== 3'b011) begin
                n_fail++;
                $display("FAIL nh_hazard%0d: got %b, want 011", k, {hazard_stall, PCWrite, IFIDWrite});
            end
            tick();
            e = sb.pop_front(); o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL nh_advance%0d: got %h, want %h", k, o, e);
            end
            $display("no-hazard case %0d: rs=%0d valid=%0b", k, o.rs, o.valid);
        end
    endtask

    task automatic test_flush();
        pkt_t p, e, o;
        int unsigned cnt_before;
        p = rand_pkt(1'b1, 5'd4, 5'd9);
        drive(p, 1'b0);
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL fl_load: got %h, want %h", o, e);
        end
        cnt_before = cnt_m;
        p = rand_pkt(1'b0, 5'd7, 5'd9);
        drive(p, 1'b1);
        n_checks++;
        if ({hazard_stall, PCWrite, IFIDWrite} !== 3'b111) begin
            n_fail++;
            $display("FAIL fl_priority: got %b, want 111", {hazard_stall, PCWrite, IFIDWrite});
        end
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e || o !== pkt_t'('0)) begin
            n_fail++;
            $display("FAIL fl_bubble: got %h, want %h", o, e);
        end
        $display("flush bubble: valid=%0b", o.valid);
`ifdef IDEX_STALL_CNT_EN
        n_checks++;
        if (stall_count !== 16'(cnt_before)) begin
            n_fail++;
            $display("FAIL fl_count: got %0d, want %0d", stall_count, cnt_before);
        end
`endif
    endtask

    task automatic test_async_reset();
        pkt_t p, e, o;
        p = rand_pkt(1'b0, 5'd1, 5'd2);
        p.read_data1 = 32'hDEADBEEF;
        drive(p, 1'b0);
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e || IDEX_ReadData1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ar_load: got %h, want %h", o, e);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        o = observed();
        n_checks++;
        if (o !== pkt_t'('0)) begin
            n_fail++;
            $display("FAIL ar_clear: got %h, want 0", o);
        end
        rst = 1'b0;
        ex_m = '0; pending_m = '0; cnt_m = 0; sb.delete();
        $display("async reset mid-cycle: rd1=%h", IDEX_ReadData1);
        // Reset during a pending load-use stall.
        p = rand_pkt(1'b1, 5'd3, 5'd4);
        drive(p, 1'b0);
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL ar_lw: got %h, want %h", o, e);
        end
        p = rand_pkt(1'b0, 5'd4, 5'd6);
        drive(p, 1'b0);
        n_checks++;
        if (hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_stall_pre: got %b, want 1", hazard_stall);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({hazard_stall, PCWrite, IFIDWrite} !== 3'b011 || observed() !== pkt_t'('0)) begin
            n_fail++;
            $display("FAIL ar_stall_drop: got %b, want 011", {hazard_stall, PCWrite, IFIDWrite});
        end
        rst = 1'b0;
        ex_m = '0; cnt_m = 0; sb.delete();
        pending_m = p;
        sb.push_back(p);
        tick();
        e = sb.pop_front(); o = observed();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL ar_resume: got %h, want %h", o, e);
        end
        $display("resume after reset: rs=%0d valid=%0b", o.rs, o.valid);
    endtask

    task automatic test_back_to_back();
        pkt_t p, e, o;
        logic f;
        logic hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!hold) begin
                p = rand_pkt(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                p.valid = ($urandom_range(0, 7) != 0);
            end
            f = ($urandom_range(0, 5) == 0);
            drive(p, f);
            n_checks++;
            if ({hazard_stall, PCWrite, IFIDWrite} !== {exp_haz, exp_pcw, exp_pcw}) begin
                n_fail++;
                $display("FAIL b2b_hazard %0d: got %b, want %b", i,
                         {hazard_stall, PCWrite, IFIDWrite}, {exp_haz, exp_pcw, exp_pcw});
            end
            hold = !exp_pcw;
            tick();
            e = sb.pop_front(); o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_regs %0d: got %h, want %h", i, o, e);
            end
            $display("b2b txn %0d: flush=%0b stall=%0b rs=%0d rt=%0d valid=%0b", i, f, hold, o.rs, o.rt, o.valid);
        end
`ifdef IDEX_STALL_CNT_EN
        n_checks++;
        if (stall_count !== 16'(cnt_m)) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, want %0d", stall_count, cnt_m);
        end
`endif
    endtask

`ifdef IDEX_STALL_CNT_EN
    task automatic test_stall_saturate();
        int unsigned k;
        @(negedge clk);
        flush = 1'b0;
        k = 32'hFFFE - cnt_m;
        force dut.hazard_stall = 1'b1;
        repeat (k) @(posedge clk);
        #1;
        n_checks++;
        if (stall_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_pre: got %h, want fffe", stall_count);
        end
        repeat (70000 - k) @(posedge clk);
        #1;
        n_checks++;
        if (stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h, want ffff", stall_count);
        end
        release dut.hazard_stall;
        $display("stall counter after 70000 forced stalls: %h", stall_count);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        IFID_RegisterRs = '0; IFID_RegisterRt = '0; IFID_valid = 1'b0; ID_RegisterRd = '0;
        ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemtoReg = 1'b0;
        ID_ALUSrc = 1'b0; ID_RegDst = 1'b0; ID_ALUOp = '0;
        ID_ReadData1 = '0; ID_ReadData2 = '0; ID_SignImm = '0;
        ex_m = '0; pending_m = '0; cnt_m = 0;
        test_reset();
        test_pass();
        test_load_use();
        test_no_hazard_cases();
        test_flush();
        test_async_reset();
        test_back_to_back();
`ifdef IDEX_STALL_CNT_EN
        test_stall_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
